// File: rtl/adder_pkg.sv
// Shared constants, FSM encoding and delay-line payload for the adder checker.
package adder_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned IDX_W  = 16;
    localparam int unsigned CNT_W  = 16;

    // Galois LFSR feedback mask and per-operand seeds
    localparam logic [DATA_W-1:0] LFSR_POLY = 32'h8020_0003;
    localparam logic [DATA_W-1:0] SEED_A    = 32'h0000_0001;
    localparam logic [DATA_W-1:0] SEED_B    = 32'h1234_ACE1;

    // Fixed corner vectors issued ahead of the pseudo-random stream
    localparam logic [DATA_W-1:0] CORNER0_A = 32'hFFFF_FFFF;
    localparam logic [DATA_W-1:0] CORNER0_B = 32'h0000_0001;
    localparam logic [DATA_W-1:0] CORNER1_A = 32'h8000_0000;
    localparam logic [DATA_W-1:0] CORNER1_B = 32'h8000_0000;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // One in-flight vector awaiting its result from the adder
    typedef struct packed {
        logic              valid;
        logic [IDX_W-1:0]  idx;
        logic [DATA_W:0]   exp;
    } dl_entry_t;

    // Reference sum with carry-out, mirroring the adder's zero extension
    function automatic logic [DATA_W:0] exp_sum(input logic [DATA_W-1:0] a,
                                                input logic [DATA_W-1:0] b);
        return {1'b0, a} + {1'b0, b};
    endfunction

endpackage

// File: rtl/adder_checker_lfsr32.sv
// 32-bit Galois LFSR with synchronous seed load and advance enable.
module lfsr32
    import adder_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] seed,
    input  logic              load,
    input  logic              advance,
    output logic [DATA_W-1:0] q
);

    logic [DATA_W-1:0] step_c;

    // Right-shifting Galois step: feedback taps applied when the LSB falls out
    always_comb begin
        step_c = q >> 1;
        if (q[0]) begin
            step_c = step_c ^ LFSR_POLY;
        end
    end

    // State register; load takes priority over advance
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= '0;
        end else if (load) begin
            q <= seed;
        end else if (advance) begin
            q <= step_c;
        end
    end

endmodule

// File: rtl/adder_checker.sv
// Stimulus generator and result checker for the registered 32-bit adder.
module adder_checker
    import adder_pkg::*;
#(
    parameter int unsigned N_OPS   = 256,
    parameter int unsigned LATENCY = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    output logic [DATA_W-1:0] ina,
    output logic [DATA_W-1:0] inb,
    input  logic [DATA_W-1:0] res,
    input  logic              ovfl,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [CNT_W-1:0]  err_cnt,
    output logic [IDX_W-1:0]  fail_idx,
    output logic [DATA_W:0]   fail_exp
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_OPS - 1);

    state_t            state_q, state_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [DATA_W-1:0] ina_d, inb_d;
    logic              busy_d, done_d, pass_d;
    logic [CNT_W-1:0]  err_cnt_d;
    logic [IDX_W-1:0]  fail_idx_d;
    logic [DATA_W:0]   fail_exp_d;

    logic              lfsr_load_c, lfsr_adv_c;
    logic [DATA_W-1:0] lfsr_a_q, lfsr_b_q;

    dl_entry_t         dl_q [LATENCY];
    dl_entry_t         push_c;
    dl_entry_t         head_c;
    logic              mismatch_c;
    logic              pending_c;

    lfsr32 u_lfsr_a (
        .clk     (clk),
        .rst_n   (rst_n),
        .seed    (SEED_A),
        .load    (lfsr_load_c),
        .advance (lfsr_adv_c),
        .q       (lfsr_a_q)
    );

    lfsr32 u_lfsr_b (
        .clk     (clk),
        .rst_n   (rst_n),
        .seed    (SEED_B),
        .load    (lfsr_load_c),
        .advance (lfsr_adv_c),
        .q       (lfsr_b_q)
    );

    // Head compare and drain-completion detect
    always_comb begin
        head_c     = dl_q[LATENCY-1];
        mismatch_c = head_c.valid && ({ovfl, res} != head_c.exp);
        pending_c  = 1'b0;
        for (int i = 0; i < int'(LATENCY) - 1; i++) begin
            pending_c = pending_c | dl_q[i].valid;
        end
    end

    // Next-state, operand selection and result bookkeeping
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        ina_d       = '0;
        inb_d       = '0;
        lfsr_load_c = 1'b0;
        lfsr_adv_c  = 1'b0;
        push_c      = '0;
        err_cnt_d   = err_cnt;
        fail_idx_d  = fail_idx;
        fail_exp_d  = fail_exp;
        pass_d      = pass;

        if (mismatch_c) begin
            if (err_cnt != '1) begin
                err_cnt_d = err_cnt + CNT_W'(1);
            end
            if (err_cnt == '0) begin
                fail_idx_d = head_c.idx;
                fail_exp_d = head_c.exp;
            end
        end

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d     = ST_RUN;
                    idx_d       = '0;
                    ina_d       = CORNER0_A;
                    inb_d       = CORNER0_B;
                    lfsr_load_c = 1'b1;
                    err_cnt_d   = '0;
                    fail_idx_d  = '0;
                    fail_exp_d  = '0;
                    pass_d      = 1'b0;
                end
            end
            ST_RUN: begin
                push_c = '{valid: 1'b1, idx: idx_q, exp: exp_sum(ina, inb)};
                if (idx_q == LAST_IDX) begin
                    state_d = ST_DRAIN;
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                    if (idx_q == '0) begin
                        ina_d = CORNER1_A;
                        inb_d = CORNER1_B;
                    end else begin
                        ina_d      = lfsr_a_q;
                        inb_d      = lfsr_b_q;
                        lfsr_adv_c = 1'b1;
                    end
                end
            end
            ST_DRAIN: begin
                if (!pending_c) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d == ST_RUN) || (state_d == ST_DRAIN);
        done_d = (state_d == ST_DONE);
        if (state_d == ST_DONE) begin
            pass_d = (err_cnt_d == '0);
        end
    end

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Registered outputs and issue index
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_q    <= '0;
            ina      <= '0;
            inb      <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            pass     <= 1'b0;
            err_cnt  <= '0;
            fail_idx <= '0;
            fail_exp <= '0;
        end else begin
            idx_q    <= idx_d;
            ina      <= ina_d;
            inb      <= inb_d;
            busy     <= busy_d;
            done     <= done_d;
            pass     <= pass_d;
            err_cnt  <= err_cnt_d;
            fail_idx <= fail_idx_d;
            fail_exp <= fail_exp_d;
        end
    end

    // Delay line aligning expected sums with the adder's register latency
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(LATENCY); i++) begin
                dl_q[i] <= '0;
            end
        end else begin
            dl_q[0] <= push_c;
            for (int i = 1; i < int'(LATENCY); i++) begin
                dl_q[i] <= dl_q[i-1];
            end
        end
    end

endmodule

// File: tb/tb_adder_checker.sv
// Bench for adder_checker: short runs against a table, long run against a scoreboard.
module tb_adder_checker;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Short-run instance (N_OPS=2) with its own adder model and fault hook
    logic        start2;
    logic [31:0] ina2, inb2, res2;
    logic        ovfl2, busy2, done2, pass2, force_ovfl0;
    logic [15:0] err2, fidx2;
    logic [32:0] fexp2, sum2_q;

    // Long-run instance (N_OPS=256)
    logic        start8;
    logic [31:0] ina8, inb8, res8;
    logic        ovfl8, busy8, done8, pass8;
    logic [15:0] err8, fidx8;
    logic [32:0] fexp8, sum8_q;

    adder_checker #(.N_OPS(2), .LATENCY(1)) dut2 (
        .clk(clk), .rst_n(rst_n), .start(start2), .ina(ina2), .inb(inb2),
        .res(res2), .ovfl(ovfl2), .busy(busy2), .done(done2), .pass(pass2),
        .err_cnt(err2), .fail_idx(fidx2), .fail_exp(fexp2)
    );

    adder_checker #(.N_OPS(256), .LATENCY(1)) dut8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .ina(ina8), .inb(inb8),
        .res(res8), .ovfl(ovfl8), .busy(busy8), .done(done8), .pass(pass8),
        .err_cnt(err8), .fail_idx(fidx8), .fail_exp(fexp8)
    );

    // Registered adders, one cycle latency
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum2_q <= '0;
            sum8_q <= '0;
        end else begin
            sum2_q <= {1'b0, ina2} + {1'b0, inb2};
            sum8_q <= {1'b0, ina8} + {1'b0, inb8};
        end
    end
    assign res2  = sum2_q[31:0];
    assign ovfl2 = sum2_q[32] & ~force_ovfl0;
    assign res8  = sum8_q[31:0];
    assign ovfl8 = sum8_q[32];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] ref_step(input logic [31:0] x);
        logic [31:0] y;
        y = {1'b0, x[31:1]};
        if (x[0]) y = y ^ 32'h8020_0003;
        return y;
    endfunction

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
    } opnd_t;

    typedef struct {
        logic [31:0] ina;
        logic [31:0] inb;
        logic        busy;
        logic        done;
        logic        pass;
        logic [15:0] err;
        logic [15:0] fidx;
        logic [32:0] fexp;
    } vec_t;

    vec_t  rows [15];
    opnd_t sb_q [$];

    initial begin
        logic [31:0] la, lb;
        opnd_t       got, want;
        int          busy_cnt, done_cnt, done_at;

        // Expected dut2 outputs on cycles T+1..T+5 for three back-to-back runs:
        // healthy, ovfl forced low at T+2, healthy again after the failing run.
        rows[0]  = '{32'hFFFF_FFFF, 32'h1,         1, 0, 0, 16'd0, 16'd0, 33'h0};
        rows[1]  = '{32'h8000_0000, 32'h8000_0000, 1, 0, 0, 16'd0, 16'd0, 33'h0};
        rows[2]  = '{32'h0,         32'h0,         1, 0, 0, 16'd0, 16'd0, 33'h0};
        rows[3]  = '{32'h0,         32'h0,         0, 1, 1, 16'd0, 16'd0, 33'h0};
        rows[4]  = '{32'h0,         32'h0,         0, 0, 1, 16'd0, 16'd0, 33'h0};
        rows[5]  = '{32'hFFFF_FFFF, 32'h1,         1, 0, 0, 16'd0, 16'd0, 33'h0};
        rows[6]  = '{32'h8000_0000, 32'h8000_0000, 1, 0, 0, 16'd0, 16'd0, 33'h0};
        rows[7]  = '{32'h0,         32'h0,         1, 0, 0, 16'd1, 16'd0, 33'h1_0000_0000};
        rows[8]  = '{32'h0,         32'h0,         0, 1, 0, 16'd1, 16'd0, 33'h1_0000_0000};
        rows[9]  = '{32'h0,         32'h0,         0, 0, 0, 16'd1, 16'd0, 33'h1_0000_0000};
        for (int i = 0; i < 5; i++) rows[10+i] = rows[i];

        rst_n       = 1'b0;
        start2      = 1'b0;
        start8      = 1'b0;
        force_ovfl0 = 1'b0;

        // Reset held: start toggling must not wake anything up
        done_cnt = 0;
        for (int i = 0; i < 4; i++) begin
            start2 = ~start2;
            start8 = ~start8;
            tick();
            if (done2 || done8) done_cnt++;
        end
        check("rst_outs2", {ina2, inb2, busy2, done2, pass2, err2, fidx2, 31'd0},
              64'd0);
        check("rst_fexp2", 64'(fexp2), 64'd0);
        check("rst_outs8", {ina8, inb8, busy8, done8, pass8, err8}, 64'd0);
        check("rst_nodone", 64'(done_cnt), 64'd0);
        start2 = 1'b0;
        start8 = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        tick();

        // Table-driven N_OPS=2 runs
        for (int run = 0; run < 3; run++) begin
            start2 = 1'b1;
            tick();
            start2 = 1'b0;
            for (int off = 1; off <= 5; off++) begin
                int r;
                r = run * 5 + off - 1;
                force_ovfl0 = (run == 1) && (off == 2);
                check($sformatf("r%0d_t%0d_ina", run, off), 64'(ina2), 64'(rows[r].ina));
                check($sformatf("r%0d_t%0d_inb", run, off), 64'(inb2), 64'(rows[r].inb));
                check($sformatf("r%0d_t%0d_busy", run, off), 64'(busy2), 64'(rows[r].busy));
                check($sformatf("r%0d_t%0d_done", run, off), 64'(done2), 64'(rows[r].done));
                check($sformatf("r%0d_t%0d_pass", run, off), 64'(pass2), 64'(rows[r].pass));
                check($sformatf("r%0d_t%0d_err", run, off), 64'(err2), 64'(rows[r].err));
                check($sformatf("r%0d_t%0d_fidx", run, off), 64'(fidx2), 64'(rows[r].fidx));
                check($sformatf("r%0d_t%0d_fexp", run, off), 64'(fexp2), 64'(rows[r].fexp));
                if (off < 5) tick();
            end
            force_ovfl0 = 1'b0;
            tick();
        end

        // Long run: queue the expected operand stream, pop as operands appear
        la = 32'h0000_0001;
        lb = 32'h1234_ACE1;
        sb_q.push_back('{32'hFFFF_FFFF, 32'h0000_0001});
        sb_q.push_back('{32'h8000_0000, 32'h8000_0000});
        for (int k = 2; k < 256; k++) begin
            sb_q.push_back('{la, lb});
            la = ref_step(la);
            lb = ref_step(lb);
        end
        start8 = 1'b1;
        tick();
        start8 = 1'b0;
        busy_cnt = 0;
        done_cnt = 0;
        done_at  = -1;
        for (int c = 1; c <= 300; c++) begin
            start8 = (c == 5);
            if (busy8) busy_cnt++;
            if (done8) begin
                done_cnt++;
                if (done_at < 0) done_at = c;
                check("long_pass_at_done", 64'(pass8), 64'd1);
                check("long_err_at_done", 64'(err8), 64'd0);
            end
            if (c == 3) check("long_idx2_ops", {ina8, inb8}, {32'h0000_0001, 32'h1234_ACE1});
            if (c <= 256) begin
                got = '{ina8, inb8};
                if (sb_q.size() == 0) begin
                    check("long_sb_empty", 64'd1, 64'd0);
                end else begin
                    want = sb_q.pop_front();
                    check($sformatf("long_op%0d", c - 1), 64'(got), 64'(want));
                end
            end
            tick();
        end
        start8 = 1'b0;
        check("long_busy_cycles", 64'(busy_cnt), 64'd257);
        check("long_done_cycle", 64'(done_at), 64'd258);
        check("long_done_count", 64'(done_cnt), 64'd1);
        check("long_ops_after", {ina8, inb8}, 64'd0);

        // Asynchronous reset while index 10 is on the bus
        start8 = 1'b1;
        tick();
        start8 = 1'b0;
        for (int c = 1; c < 11; c++) tick();
        la = 32'h0000_0001;
        lb = 32'h1234_ACE1;
        for (int k = 2; k < 10; k++) begin
            la = ref_step(la);
            lb = ref_step(lb);
        end
        check("mid_idx10_ops", {ina8, inb8}, {la, lb});
        rst_n = 1'b0;
        #1;
        check("mid_rst_ops", {ina8, inb8}, 64'd0);
        check("mid_rst_flags", {busy8, done8, pass8, err8, fidx8}, 64'd0);
        check("mid_rst_fexp", 64'(fexp8), 64'd0);
        tick();
        tick();
        rst_n = 1'b1;
        done_cnt = 0;
        for (int c = 0; c < 300; c++) begin
            if (done8 || busy8) done_cnt++;
            tick();
        end
        check("mid_no_done", 64'(done_cnt), 64'd0);
        start8 = 1'b1;
        tick();
        start8 = 1'b0;
        check("restart_idx0", {ina8, inb8}, {32'hFFFF_FFFF, 32'h0000_0001});
        tick();
        check("restart_idx1", {ina8, inb8}, {32'h8000_0000, 32'h8000_0000});

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
